multicycle_controller: RTL and testbench

- Control unit for the multicycle ARM-subset datapath (ADD/SUB/AND/ORR, LDR/STR, B).
- Holds the main sequencing FSM, the ALU-function decode, the condition-check logic and the NZCV flag register.
- Drives every mux select and write enable of the shared-memory datapath, one instruction every 3–5 cycles.

---
 rtl/multicycle_controller_if.sv | 59 +++++
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//   Bundle between the multicycle datapath and its control unit.
//   Instruction fields and ALU flags flow from the datapath to the controller;
//   mux selects and write enables flow back.
//
//   Signals:
//     Cond[3:0]       Instr[31:28] condition field
//     Op[1:0]         Instr[27:26] instruction class
//     Funct[5:0]      Instr[25:20] {I, cmd[3:0], S}
//     Rd[3:0]         Instr[15:12] destination register
//     ALUFlags[3:0]   {N,Z,C,V} from the ALU in the current cycle
//     PCWrite         PC register enable
//     AdrSrc          memory address select (0=PC, 1=ALUResult register)
//     MemWrite        memory write enable
//     IRWrite         instruction register enable
//     ResultSrc[1:0]  result select (00=ALUOut, 01=Data, 10=ALUResult)
//     ALUSrcA         ALU A select (0=RD1 register, 1=PC)
//     ALUSrcB[1:0]    ALU B select (00=RD2 register, 01=ExtImm, 10=constant 4)
//     ALUControl[1:0] 00=ADD, 01=SUB, 10=AND, 11=ORR
//     ImmSrc[1:0]     immediate-extension select
//     RegSrc[1:0]     register-file read address selects
//     RegWrite        register-file write enable
//
//   Modports:
//     master  datapath side (drives instruction fields and flags)
//     slave   controller side (drives selects and enables)
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       RegWrite;

   modport master (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegSrc, RegWrite
   );

   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegSrc, RegWrite
   );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control unit for the multicycle ARM-subset datapath (ADD/SUB/AND/ORR,
//   LDR/STR, B). Contains the Moore sequencing FSM, the ALU-function decode,
//   the condition check, the registered condition result and the NZCV flags.
//   One instruction completes every 3 to 5 cycles.
//
//   Ports:
//     clk       in  system clock, rising edge
//     reset_n   in  synchronous active-low reset
//     ctrl_if   slave modport of multicycle_controller_if (instruction fields
//               and ALU flags in; selects and enables out)
//
//   Build option:
//     CTRL_CMP_EN  when defined, cmd=1010 (CMP) decodes as SUB and the
//                  instruction retires straight from execute without a
//                  register write-back. When undefined, 1010 decodes as ADD
//                  and follows the normal write-back path.
// -----------------------------------------------------------------------------
module multicycle_controller (
   input  logic                   clk,
   input  logic                   reset_n,
   multicycle_controller_if.slave ctrl_if
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   state_t     state_out;      // state that drives the outputs
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;

   // per-state internal controls
   logic       next_pc, branch, reg_w, mem_w, alu_op, ir_write, adr_src, alu_src_a;
   logic [1:0] result_src, alu_src_b;

   // ALU decode
   logic [1:0] alu_dec;
   logic [1:0] alu_ctl;
   logic [1:0] flag_w;
   logic       cond_pass;
   logic       pcs;
`ifdef CTRL_CMP_EN
   logic       is_cmp;
`endif

   // -------------------------------------------------------------------------
   // State, flag and condition registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   // -------------------------------------------------------------------------
   // ALU function decode on cmd = Funct[4:1]
   // -------------------------------------------------------------------------
   always_comb begin
      alu_dec = 2'b00;
`ifdef CTRL_CMP_EN
      is_cmp  = 1'b0;
`endif
      case (ctrl_if.Funct[4:1])
         4'b0100: alu_dec = 2'b00;   // ADD
         4'b0010: alu_dec = 2'b01;   // SUB
         4'b0000: alu_dec = 2'b10;   // AND
         4'b1100: alu_dec = 2'b11;   // ORR
`ifdef CTRL_CMP_EN
         4'b1010: begin              // CMP: subtract, flags only
            alu_dec = 2'b01;
            is_cmp  = 1'b1;
         end
`endif
         default: alu_dec = 2'b00;   // unsupported commands fall back to ADD
      endcase
   end

   assign alu_ctl = alu_op ? alu_dec : 2'b00;
   // C and V only make sense for arithmetic results, so logic ops leave them
   assign flag_w  = alu_op ? {ctrl_if.Funct[0],
                              ctrl_if.Funct[0] & (alu_dec == 2'b00 || alu_dec == 2'b01)}
                           : 2'b00;

   // -------------------------------------------------------------------------
   // Condition check against the architectural flags {N,Z,C,V}
   // -------------------------------------------------------------------------
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags_q;
      cond_pass = 1'b0;
      case (ctrl_if.Cond)
         4'b0000: cond_pass = z;                 // EQ
         4'b0001: cond_pass = ~z;                // NE
         4'b0010: cond_pass = c;                 // CS
         4'b0011: cond_pass = ~c;                // CC
         4'b0100: cond_pass = n;                 // MI
         4'b0101: cond_pass = ~n;                // PL
         4'b0110: cond_pass = v;                 // VS
         4'b0111: cond_pass = ~v;                // VC
         4'b1000: cond_pass = c & ~z;            // HI
         4'b1001: cond_pass = ~(c & ~z);         // LS
         4'b1010: cond_pass = (n == v);          // GE
         4'b1011: cond_pass = (n != v);          // LT
         4'b1100: cond_pass = ~z & (n == v);     // GT
         4'b1101: cond_pass = ~(~z & (n == v));  // LE
         4'b1110: cond_pass = 1'b1;              // AL
         default: cond_pass = 1'b0;              // 1111 never executes
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic and per-state controls
   // -------------------------------------------------------------------------
   // While reset is held the selects present FETCH values so the datapath is
   // already pointed at the PC when reset releases.
   assign state_out = reset_n ? state_q : S_FETCH;

   always_comb begin
      state_d    = state_q;
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      alu_op     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;

      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (ctrl_if.Op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = ctrl_if.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = ctrl_if.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTER,
         S_EXECUTEI: begin
`ifdef CTRL_CMP_EN
            state_d = is_cmp ? S_FETCH : S_ALUWB;
`else
            state_d = S_ALUWB;
`endif
         end
         default:    state_d = S_FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH
      endcase

      case (state_out)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            next_pc    = 1'b1;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR:   alu_src_b = 2'b01;
         S_MEMRD:    adr_src   = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            alu_src_b = 2'b01;
            alu_op    = 1'b1;
         end
         S_ALUWB:    reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Flag and condition-result updates
   // -------------------------------------------------------------------------
   always_comb begin
      flags_d = flags_q;
      if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && cond_ex_q) begin
         if (flag_w[1]) flags_d[3:2] = ctrl_if.ALUFlags[3:2];
         if (flag_w[0]) flags_d[1:0] = ctrl_if.ALUFlags[1:0];
      end
   end

   // the condition is sampled once per instruction, against pre-instruction flags
   assign cond_ex_d = (state_q == S_DECODE) ? cond_pass : cond_ex_q;

   // -------------------------------------------------------------------------
   // Outputs; enables are additionally masked by reset
   // -------------------------------------------------------------------------
   // a register write to R15 is a jump
   assign pcs = branch | (reg_w & (ctrl_if.Rd == 4'd15));

   assign ctrl_if.PCWrite    = reset_n & (next_pc | (pcs & cond_ex_q));
   assign ctrl_if.IRWrite    = reset_n & ir_write;
   assign ctrl_if.RegWrite   = reset_n & reg_w & cond_ex_q;
   assign ctrl_if.MemWrite   = reset_n & mem_w & cond_ex_q;
   assign ctrl_if.AdrSrc     = adr_src;
   assign ctrl_if.ResultSrc  = result_src;
   assign ctrl_if.ALUSrcA    = alu_src_a;
   assign ctrl_if.ALUSrcB    = alu_src_b;
   assign ctrl_if.ALUControl = alu_ctl;
   assign ctrl_if.ImmSrc     = ctrl_if.Op;
   assign ctrl_if.RegSrc     = {(ctrl_if.Op == 2'b01), (ctrl_if.Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed bench for multicycle_controller. Walks a fixed program of
//   instructions through the FSM and checks the control word in each state,
//   the reset behaviour and the flag register.
//   Control word layout used for comparisons (12 bits):
//     {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA,
//      ALUSrcB[1:0], ALUControl[1:0], RegWrite}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic clk;
   logic reset_n;
   int   n_assert;
   int   n_fail;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ctrl_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   function automatic logic [11:0] ctl();
      return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite};
   endfunction

   function automatic logic [11:0] pk(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic [1:0] res,
                                      input logic srca, input logic [1:0] srcb,
                                      input logic [1:0] aluc, input logic regw);
      return {pcw, adr, memw, irw, res, srca, srcb, aluc, regw};
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] cond, input logic [1:0] op,
                            input logic [5:0] funct, input logic [3:0] rd);
      bus.Cond  = cond;
      bus.Op    = op;
      bus.Funct = funct;
      bus.Rd    = rd;
      #1;
   endtask

   // frequently used expected control words
   logic [11:0] W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_RST;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      W_FETCH  = pk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0);
      W_DECODE = pk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0);
      W_MEMADR = pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0);
      W_MEMRD  = pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
      W_RST    = pk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0);

      bus.ALUFlags = 4'b0000;
      reset_n      = 1'b0;
      set_instr(4'b1110, 2'b01, 6'b000000, 4'd2);   // STR R2, AL
      step();
      step();
      chk("reset_flags", {8'd0, dut.flags_q}, 12'd0);
      chk("reset_held_outputs", ctl(), W_RST);
      reset_n = 1'b1;
      #1;

      // ---- STR AL, then reset asserted while in MEMWR ----
      chk("str_fetch", ctl(), W_FETCH);
      step(); chk("str_decode", ctl(), W_DECODE);
      chk("str_immsrc_regsrc", {8'd0, bus.ImmSrc, bus.RegSrc}, {8'd0, 2'b01, 2'b10});
      step(); chk("str_memadr", ctl(), W_MEMADR);
      step(); chk("str_memwr", ctl(), pk(0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      reset_n = 1'b0;
      #1;
      chk("rst_in_memwr_c0", ctl(), W_RST);
      step(); chk("rst_in_memwr_c1", ctl(), W_RST);
      step(); chk("rst_in_memwr_c2", ctl(), W_RST);
      reset_n = 1'b1;
      #1;
      chk("rst_release_fetch", ctl(), W_FETCH);
      $display("transaction: reset during STR MEMWR checked");

      // ---- ADDS R1,R2,R3 AL, ALUFlags 0110 ----
      set_instr(4'b1110, 2'b00, 6'b001001, 4'd1);
      step(); chk("adds_decode", ctl(), W_DECODE);
      step(); chk("adds_executer", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      bus.ALUFlags = 4'b0110;
      step(); chk("adds_aluwb", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
      chk("adds_flags", {8'd0, dut.flags_q}, {8'd0, 4'b0110});
      step(); chk("adds_back_to_fetch", ctl(), W_FETCH);
      $display("transaction: ADDS R1 checked (4 cycles)");

      // ---- LDR R3 AL ----
      set_instr(4'b1110, 2'b01, 6'b011001, 4'd3);
      step(); chk("ldr_decode", ctl(), W_DECODE);
      step(); chk("ldr_memadr", ctl(), W_MEMADR);
      step(); chk("ldr_memrd", ctl(), W_MEMRD);
      step(); chk("ldr_memwb", ctl(), pk(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1));
      step(); chk("ldr_back_to_fetch", ctl(), W_FETCH);
      $display("transaction: LDR R3 checked (5 cycles)");

      // ---- ORR R4 immediate, S=0: flags must stay 0110 ----
      set_instr(4'b1110, 2'b00, 6'b111000, 4'd4);
      step(); chk("orr_decode", ctl(), W_DECODE);
      step(); chk("orr_executei", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b11, 0));
      bus.ALUFlags = 4'b1001;
      step(); chk("orr_aluwb", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
      chk("orr_flags_unchanged", {8'd0, dut.flags_q}, {8'd0, 4'b0110});
      step();
      $display("transaction: ORR R4 S=0 checked");

      // ---- BEQ with Z=1: taken ----
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      step(); chk("beq_z1_decode", ctl(), W_DECODE);
      chk("beq_immsrc_regsrc", {8'd0, bus.ImmSrc, bus.RegSrc}, {8'd0, 2'b10, 2'b01});
      step(); chk("beq_z1_branch", ctl(), pk(1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0));
      step();
      $display("transaction: BEQ Z=1 checked");

      // ---- SUBS AL, ALUFlags 0001: flags become 0001 ----
      set_instr(4'b1110, 2'b00, 6'b000101, 4'd6);
      step();
      step(); chk("subs_executer", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0));
      bus.ALUFlags = 4'b0001;
      step(); chk("subs_flags", {8'd0, dut.flags_q}, {8'd0, 4'b0001});
      step();
      $display("transaction: SUBS R6 checked");

      // ---- BEQ with Z=0: not taken ----
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      step();
      step(); chk("beq_z0_branch", ctl(), pk(0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0));
      step();
      $display("transaction: BEQ Z=0 checked");

      // ---- STREQ with Z=0: write suppressed ----
      set_instr(4'b0000, 2'b01, 6'b000000, 4'd2);
      step();
      step(); chk("streq_memadr", ctl(), W_MEMADR);
      step(); chk("streq_memwr", ctl(), pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      step();
      $display("transaction: STREQ Z=0 checked");

      // ---- ADD PC (Rd=15), AL, S=0: ALUWB also writes PC ----
      set_instr(4'b1110, 2'b00, 6'b001000, 4'd15);
      step();
      step();
      bus.ALUFlags = 4'b1111;
      step(); chk("addpc_aluwb", ctl(), pk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
      chk("addpc_flags_unchanged", {8'd0, dut.flags_q}, {8'd0, 4'b0001});
      step();
      $display("transaction: ADD R15 checked");

      // ---- Op=11: DECODE returns straight to FETCH ----
      set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
      step(); chk("op11_decode", ctl(), W_DECODE);
      step(); chk("op11_fetch", ctl(), W_FETCH);
      $display("transaction: Op=11 checked");

      // ---- CMP R5 (cmd 1010, S=1), ALUFlags 1000 ----
      set_instr(4'b1110, 2'b00, 6'b010101, 4'd5);
      step();
      step();
`ifdef CTRL_CMP_EN
      chk("cmp_executer", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0));
      bus.ALUFlags = 4'b1000;
      step(); chk("cmp_fetch_no_aluwb", ctl(), W_FETCH);
      chk("cmp_flags", {8'd0, dut.flags_q}, {8'd0, 4'b1000});
`else
      chk("cmp_executer", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
      bus.ALUFlags = 4'b1000;
      step(); chk("cmp_aluwb", ctl(), pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
      chk("cmp_flags", {8'd0, dut.flags_q}, {8'd0, 4'b1000});
      step(); chk("cmp_fetch", ctl(), W_FETCH);
`endif
      $display("transaction: CMP R5 checked");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
